// File: rtl/pip_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pip_hazard_ctrl
// Hazard detection and next-PC control beside the ID stage of the 5-stage CPU.
// It detects load-use and branch-operand hazards against EX/MEM, sequences
// multi-cycle stalls with a small countdown FSM, resolves branches and jumps
// in ID, and keeps saturating stall/flush performance counters.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   id_jump, id_branch         J/JAL or conditional branch in ID
//   id_br_cond                 00 EQ, 01 NE, 10 LEZ, 11 GTZ
//   id_rs_used, id_rt_used     ID instruction reads rs / rt
//   id_rs, id_rt               ID source registers
//   id_bus_a, id_bus_b         forwarded operand values in ID
//   id_pc4, id_imm16, id_target PC+4, branch offset, jump index
//   ex_reg_wr, ex_mem_to_reg   EX instruction writes a register / is a load
//   ex_wr_reg                  EX destination register
//   mem_mem_to_reg, mem_wr_reg MEM instruction is a load / its destination
//   stall, id_ex_bubble        freeze PC + IF/ID, insert NOP into ID/EX
//   redirect, npc              load npc into PC
//   if_id_flush                clear IF/ID
//   stall_cnt, flush_cnt       saturating performance counters
// stall/id_ex_bubble/redirect/npc/if_id_flush are combinational so the PC
// and pipeline registers act on them at the very next edge.
// ---------------------------------------------------------------------------
module pip_hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DELAY_SLOT = 0,
  parameter int unsigned ZERO_GUARD = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic [1:0]        id_br_cond,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [31:0]       id_bus_a,
  input  logic [31:0]       id_bus_b,
  input  logic [31:0]       id_pc4,
  input  logic [15:0]       id_imm16,
  input  logic [25:0]       id_target,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_to_reg,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              mem_mem_to_reg,
  input  logic [REG_AW-1:0] mem_wr_reg,
  output logic              stall,
  output logic              id_ex_bubble,
  output logic              redirect,
  output logic [31:0]       npc,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned HOLD_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
  logic                ex_hit, mem_hit;
  logic [1:0]          need;
  logic                cond_true;
  logic                taken;
  logic [31:0]         br_target;
  logic [31:0]         jmp_target;

  // Operand match against a producer; register 0 optionally never matches.
  function automatic logic reg_match(input logic              used,
                                     input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] d);
    return used && (r == d) && !((ZERO_GUARD != 0) && (d == '0));
  endfunction

  assign ex_hit  = reg_match(id_rs_used, id_rs, ex_wr_reg)
                 | reg_match(id_rt_used, id_rt, ex_wr_reg);
  assign mem_hit = reg_match(id_rs_used, id_rs, mem_wr_reg)
                 | reg_match(id_rt_used, id_rt, mem_wr_reg);

  // Required stall count: later assignments win, so the 2-cycle case is last.
  always_comb begin
    need = 2'd0;
    if (ex_mem_to_reg && ex_hit)                           need = 2'd1;
    if (id_branch && ex_reg_wr && !ex_mem_to_reg && ex_hit) need = 2'd1;
    if (id_branch && mem_mem_to_reg && mem_hit)            need = 2'd1;
    if (id_branch && ex_mem_to_reg && ex_hit)              need = 2'd2;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // FSM next state and stall output
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    stall         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need != 2'd0) stall = 1'b1;
        // One cycle is stalled here; HOLD covers the remaining need-1 cycles.
        if (need == 2'd2) begin
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_W'(1);
        end
      end
      ST_HOLD: begin
        stall         = 1'b1;
        hold_cnt_next = HOLD_W'(hold_cnt - HOLD_W'(1));
        if (hold_cnt_next == '0) state_next = ST_IDLE;
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
    if (rst) stall = 1'b0;
  end

  assign id_ex_bubble = stall;

  // Branch condition on the forwarded operands
  always_comb begin
    cond_true = 1'b0;
    case (id_br_cond)
      2'b00: cond_true = (id_bus_a == id_bus_b);
      2'b01: cond_true = (id_bus_a != id_bus_b);
      2'b10: cond_true = id_bus_a[31] || (id_bus_a == 32'd0);
      2'b11: cond_true = !id_bus_a[31] && (id_bus_a != 32'd0);
      default: cond_true = 1'b0;
    endcase
  end

  assign br_target  = id_pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign jmp_target = {id_pc4[31:28], id_target, 2'b00};

  assign taken = !rst && !stall && (id_jump || (id_branch && cond_true));

  // Next-PC selection; jump wins if both jump and branch are asserted.
  always_comb begin
    redirect = taken;
    npc      = id_pc4;
    if (taken) npc = id_jump ? jmp_target : br_target;
  end

  assign if_id_flush = redirect && (DELAY_SLOT == 0);

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Directed bench: default build (dut_a) and a DELAY_SLOT=1, ZERO_GUARD=0,
// CNT_W=2 build (dut_b) share the same stimulus.
module tb_pip_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_jump, id_branch;
  logic [1:0]  id_br_cond;
  logic        id_rs_used, id_rt_used;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_bus_a, id_bus_b, id_pc4;
  logic [15:0] id_imm16;
  logic [25:0] id_target;
  logic        ex_reg_wr, ex_mem_to_reg;
  logic [4:0]  ex_wr_reg;
  logic        mem_mem_to_reg;
  logic [4:0]  mem_wr_reg;

  logic        a_stall, a_bubble, a_redirect, a_flush;
  logic [31:0] a_npc;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_stall, b_bubble, b_redirect, b_flush;
  logic [31:0] b_npc;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pip_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_jump(id_jump), .id_branch(id_branch),
    .id_br_cond(id_br_cond), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs(id_rs), .id_rt(id_rt), .id_bus_a(id_bus_a), .id_bus_b(id_bus_b),
    .id_pc4(id_pc4), .id_imm16(id_imm16), .id_target(id_target),
    .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg), .ex_wr_reg(ex_wr_reg),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_wr_reg(mem_wr_reg),
    .stall(a_stall), .id_ex_bubble(a_bubble), .redirect(a_redirect), .npc(a_npc),
    .if_id_flush(a_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pip_hazard_ctrl #(.REG_AW(5), .DELAY_SLOT(1), .ZERO_GUARD(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_jump(id_jump), .id_branch(id_branch),
    .id_br_cond(id_br_cond), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs(id_rs), .id_rt(id_rt), .id_bus_a(id_bus_a), .id_bus_b(id_bus_b),
    .id_pc4(id_pc4), .id_imm16(id_imm16), .id_target(id_target),
    .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg), .ex_wr_reg(ex_wr_reg),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_wr_reg(mem_wr_reg),
    .stall(b_stall), .id_ex_bubble(b_bubble), .redirect(b_redirect), .npc(b_npc),
    .if_id_flush(b_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic clear_inputs();
    rst = 1'b0; id_jump = 1'b0; id_branch = 1'b0; id_br_cond = 2'b00;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    id_bus_a = 32'd0; id_bus_b = 32'd0; id_pc4 = 32'h0000_1000;
    id_imm16 = 16'd0; id_target = 26'd0;
    ex_reg_wr = 1'b0; ex_mem_to_reg = 1'b0; ex_wr_reg = 5'd0;
    mem_mem_to_reg = 1'b0; mem_wr_reg = 5'd0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Hazard and jump asserted while in reset: everything must be suppressed.
    clear_inputs();
    rst = 1'b1; id_jump = 1'b1; id_target = 26'h10; id_pc4 = 32'h0000_1234;
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
    @(negedge clk);
    checks++; if ({a_stall, a_bubble, a_redirect, a_flush} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {a_stall, a_bubble, a_redirect, a_flush}); end
    checks++; if (a_npc !== 32'h0000_1234) begin
      errors++; $display("FAIL reset_npc got=%h exp=00001234", a_npc); end
    step();
    checks++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_stall_cnt, a_flush_cnt); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_to_reg = 1'b1; ex_reg_wr = 1'b1; ex_wr_reg = 5'd8;
    id_rs = 5'd8; id_rs_used = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1 || a_bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_stall got=%b%b exp=11", a_stall, a_bubble); end
    step();
    ex_mem_to_reg = 1'b0; ex_reg_wr = 1'b0;   // bubble now in EX
    mem_mem_to_reg = 1'b1; mem_wr_reg = 5'd8; // non-branch: no MEM hazard
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_release got=%b exp=0", a_stall); end
    step();
    checks++; if (a_stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt got=%0d exp=1", a_stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_branch_alu();
    do_reset();
    // ALU producer in EX, non-branch consumer: forwarded, no stall.
    ex_reg_wr = 1'b1; ex_wr_reg = 5'd4; id_rs = 5'd4; id_rs_used = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin
      errors++; $display("FAIL alu_nobranch got=%b exp=0", a_stall); end
    // Same producer, branch consumer: one stall.
    id_branch = 1'b1; id_br_cond = 2'b01; id_bus_a = 32'd1; id_bus_b = 32'd2;
    #1;
    checks++; if (a_stall !== 1'b1 || a_redirect !== 1'b0) begin
      errors++; $display("FAIL branch_alu got=%b%b exp=10", a_stall, a_redirect); end
    step();
    ex_reg_wr = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_redirect !== 1'b1) begin
      errors++; $display("FAIL branch_alu_resolve got=%b%b exp=01", a_stall, a_redirect); end
    clear_inputs();
  endtask

  task automatic test_branch_ex_load();
    do_reset();
    id_branch = 1'b1; id_br_cond = 2'b00; id_rt = 5'd9; id_rt_used = 1'b1;
    id_rs = 5'd3; id_rs_used = 1'b1; id_bus_a = 32'd5; id_bus_b = 32'd5;
    id_pc4 = 32'h0000_0100; id_imm16 = 16'hFFFF;
    ex_mem_to_reg = 1'b1; ex_reg_wr = 1'b1; ex_wr_reg = 5'd9;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1 || a_bubble !== 1'b1 || a_redirect !== 1'b0) begin
      errors++; $display("FAIL ex_load_t got=%b%b%b exp=110", a_stall, a_bubble, a_redirect); end
    step();
    // No hazard visible in t+1, but HOLD must keep stalling.
    ex_mem_to_reg = 1'b0; ex_reg_wr = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1 || a_bubble !== 1'b1 || a_redirect !== 1'b0) begin
      errors++; $display("FAIL ex_load_hold got=%b%b%b exp=110", a_stall, a_bubble, a_redirect); end
    step();
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_redirect !== 1'b1 || a_flush !== 1'b1) begin
      errors++; $display("FAIL ex_load_resolve got=%b%b%b exp=011", a_stall, a_redirect, a_flush); end
    checks++; if (a_npc !== 32'h0000_00FC) begin
      errors++; $display("FAIL ex_load_npc got=%h exp=000000fc", a_npc); end
    step();
    clear_inputs();
    checks++; if (a_stall_cnt !== 16'd2 || a_flush_cnt !== 16'd1) begin
      errors++; $display("FAIL ex_load_cnt got=%0d/%0d exp=2/1", a_stall_cnt, a_flush_cnt); end
  endtask

  task automatic test_branch_mem_load();
    do_reset();
    id_branch = 1'b1; id_br_cond = 2'b00; id_rs = 5'd12; id_rs_used = 1'b1;
    mem_mem_to_reg = 1'b1; mem_wr_reg = 5'd12; id_bus_a = 32'd1; id_bus_b = 32'd2;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin
      errors++; $display("FAIL mem_load_stall got=%b exp=1", a_stall); end
    step();
    mem_mem_to_reg = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_redirect !== 1'b0 || a_npc !== 32'h0000_1000) begin
      errors++; $display("FAIL mem_load_resolve got=%b%b %h exp=00 00001000", a_stall, a_redirect, a_npc); end
    clear_inputs();
  endtask

  task automatic test_zero_guard();
    do_reset();
    ex_mem_to_reg = 1'b1; ex_reg_wr = 1'b1; ex_wr_reg = 5'd0;
    id_rs = 5'd0; id_rs_used = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin
      errors++; $display("FAIL zero_guard_on got=%b exp=0", a_stall); end
    checks++; if (b_stall !== 1'b1) begin
      errors++; $display("FAIL zero_guard_off got=%b exp=1", b_stall); end
    // Unused operand never matches.
    ex_wr_reg = 5'd8; id_rs = 5'd8; id_rs_used = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
      errors++; $display("FAIL unused_operand got=%b%b exp=00", a_stall, b_stall); end
    clear_inputs();
  endtask

  task automatic test_conditions();
    do_reset();
    id_branch = 1'b1; id_pc4 = 32'h0000_0200; id_imm16 = 16'h0004;
    id_br_cond = 2'b10; id_bus_a = 32'h8000_0000;
    @(negedge clk);
    checks++; if (a_redirect !== 1'b1 || a_npc !== 32'h0000_0210) begin
      errors++; $display("FAIL blez_neg got=%b %h exp=1 00000210", a_redirect, a_npc); end
    id_br_cond = 2'b11; id_bus_a = 32'd0;
    #1;
    checks++; if (a_redirect !== 1'b0 || a_npc !== 32'h0000_0200 || a_flush !== 1'b0) begin
      errors++; $display("FAIL bgtz_zero got=%b %h exp=0 00000200", a_redirect, a_npc); end
    id_bus_a = 32'd1;
    #1;
    checks++; if (a_redirect !== 1'b1) begin
      errors++; $display("FAIL bgtz_pos got=%b exp=1", a_redirect); end
    id_br_cond = 2'b01; id_bus_a = 32'd7; id_bus_b = 32'd7;
    #1;
    checks++; if (a_redirect !== 1'b0) begin
      errors++; $display("FAIL bne_equal got=%b exp=0", a_redirect); end
    id_br_cond = 2'b00; id_bus_b = 32'd8;
    #1;
    checks++; if (a_redirect !== 1'b0) begin
      errors++; $display("FAIL beq_ne got=%b exp=0", a_redirect); end
    id_br_cond = 2'b10; id_bus_a = 32'd0; id_imm16 = 16'h8000;
    #1;
    checks++; if (a_npc !== 32'hFFFE_0200) begin
      errors++; $display("FAIL blez_wrap got=%h exp=fffe0200", a_npc); end
    // Jump and branch together: jump target wins.
    id_jump = 1'b1; id_pc4 = 32'h4000_0008; id_target = 26'h10;
    #1;
    checks++; if (a_npc !== 32'h4000_0040) begin
      errors++; $display("FAIL jump_priority got=%h exp=40000040", a_npc); end
    clear_inputs();
  endtask

  task automatic test_jump_delay_slot();
    do_reset();
    id_jump = 1'b1; id_pc4 = 32'h4000_0008; id_target = 26'h10;
    @(negedge clk);
    checks++; if (b_redirect !== 1'b1 || b_npc !== 32'h4000_0040 || b_flush !== 1'b0) begin
      errors++; $display("FAIL jump_ds got=%b %h %b exp=1 40000040 0", b_redirect, b_npc, b_flush); end
    checks++; if (a_flush !== 1'b1) begin
      errors++; $display("FAIL jump_nods_flush got=%b exp=1", a_flush); end
    step();
    clear_inputs();
    checks++; if (b_flush_cnt !== 2'd1 || a_flush_cnt !== 16'd1) begin
      errors++; $display("FAIL jump_flush_cnt got=%0d/%0d exp=1/1", b_flush_cnt, a_flush_cnt); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    id_branch = 1'b1; id_rs = 5'd9; id_rs_used = 1'b1;
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd9;
    step();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_bubble !== 1'b0) begin
      errors++; $display("FAIL hold_reset_force got=%b%b exp=00", a_stall, a_bubble); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
      errors++; $display("FAIL hold_reset_after got=%b %0d/%0d exp=0 0/0", a_stall, a_stall_cnt, a_flush_cnt); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
    for (int i = 0; i < 5; i++) step();
    clear_inputs();
    checks++; if (b_stall_cnt !== 2'd3) begin
      errors++; $display("FAIL stall_sat got=%0d exp=3", b_stall_cnt); end
    checks++; if (a_stall_cnt !== 16'd5) begin
      errors++; $display("FAIL stall_cnt5 got=%0d exp=5", a_stall_cnt); end
    // Flush counter saturates too.
    id_jump = 1'b1;
    for (int i = 0; i < 4; i++) step();
    clear_inputs();
    checks++; if (b_flush_cnt !== 2'd3 || a_flush_cnt !== 16'd4) begin
      errors++; $display("FAIL flush_sat got=%0d/%0d exp=3/4", b_flush_cnt, a_flush_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_ex_load();
    test_branch_mem_load();
    test_zero_guard();
    test_conditions();
    test_jump_delay_slot();
    test_reset_in_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
